// File: rtl/led_sequencer.sv
// LED pattern sequencer: synchronised tick/mode/pause inputs drive a HOLD,
// ROTATE, BOUNCE or COUNT pattern on a registered LED bus with a wrap pulse.

module led_sequencer_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

module led_sequencer #(
    parameter int LED_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic             wrap
);
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

    logic       tick_s;
    logic [1:0] mode_raw_s;
    logic       pause_s;
    mode_e      mode_s;

    led_sequencer_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_tick (
        .clk(clk), .rst(rst), .d_i(tick_in), .q_o(tick_s)
    );
    led_sequencer_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_mode (
        .clk(clk), .rst(rst), .d_i(mode), .q_o(mode_raw_s)
    );
    led_sequencer_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_pause (
        .clk(clk), .rst(rst), .d_i(pause), .q_o(pause_s)
    );

    assign mode_s = mode_e'(mode_raw_s);

    // Step is registered once more after edge detection, so tick-to-LED
    // latency is SYNC_STAGES + 2 edges while mode changes take SYNC_STAGES + 1.
    logic tick_prev_q;
    logic step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_prev_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            tick_prev_q <= tick_s;
            step_q      <= tick_s & ~tick_prev_q;
        end
    end

    mode_e            cur_mode_q, cur_mode_d;
    dir_e             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             wrap_q, wrap_d;
    logic             led_onehot;

    assign led_onehot = (led_q != '0) && ((led_q & (led_q - LED_ONE)) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_mode_q <= MODE_HOLD;
            dir_q      <= DIR_LEFT;
            led_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            cur_mode_q <= cur_mode_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        cur_mode_d = cur_mode_q;
        dir_d      = dir_q;
        led_d      = led_q;
        wrap_d     = 1'b0;
        if (mode_s != cur_mode_q) begin
            // Mode change wins; any step arriving this cycle is dropped.
            cur_mode_d = mode_s;
            case (mode_s)
                MODE_ROTATE, MODE_BOUNCE: begin
                    led_d = LED_ONE;
                    dir_d = DIR_LEFT;
                end
                MODE_COUNT: led_d = '0;
                default: ;
            endcase
        end else if (step_q && !pause_s) begin
            case (cur_mode_q)
                MODE_ROTATE: begin
                    led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    wrap_d = led_q[LED_W-1];
                end
                MODE_BOUNCE: begin
                    if (!led_onehot) begin
                        led_d = LED_ONE;
                        dir_d = DIR_LEFT;
                    end else if (dir_q == DIR_LEFT) begin
                        if (led_q[LED_W-1]) begin
                            led_d = led_q >> 1;
                            dir_d = DIR_RIGHT;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = led_q << 1;
                            dir_d = DIR_LEFT;
                        end else begin
                            led_d  = led_q >> 1;
                            wrap_d = led_q[1];
                        end
                    end
                end
                MODE_COUNT: begin
                    led_d  = led_q + LED_ONE;
                    wrap_d = &led_q;
                end
                default: ;
            endcase
        end
    end

    assign led  = led_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed table, corner sequences,
// and randomized operations against a position/arithmetic reference model.

module tb_led_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic [15:0] led;
    logic        wrap;
    logic [3:0]  led4;
    logic        wrap4;

    led_sequencer #(.LED_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .mode(mode), .pause(pause),
        .led(led), .wrap(wrap)
    );
    led_sequencer #(.LED_W(4), .SYNC_STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .mode(mode), .pause(pause),
        .led(led4), .wrap(wrap4)
    );

    always #5 clk = ~clk;

    int wrap_cnt = 0;
    int wrap4_cnt = 0;
    always @(negedge clk) begin
        if (wrap)  wrap_cnt  <= wrap_cnt + 1;
        if (wrap4) wrap4_cnt <= wrap4_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: mode, pattern value, bounce position and direction.
    int          m_mode = 1;
    logic [15:0] m_led = 16'h0;
    bit          m_left = 1'b1;
    bit          m_pause = 1'b0;
    int          m_wrap = 0;

    task automatic model_op(input int op, input int arg);
        int p;
        int v;
        m_wrap = 0;
        if (op == 1) begin
            if (arg != m_mode) begin
                m_mode = arg;
                if (arg == 1 || arg == 2) begin m_led = 16'h1; m_left = 1'b1; end
                else if (arg == 3) m_led = 16'h0;
            end
        end else if (op == 2) begin
            m_pause = arg[0];
        end else if (!m_pause) begin
            case (m_mode)
                1: begin
                    v = int'(m_led) * 2;
                    if (v >= 65536) begin v = v - 65536 + 1; m_wrap = 1; end
                    m_led = 16'(v);
                end
                2: begin
                    if (m_led == 0 || (m_led & (m_led - 16'h1)) != 0) begin
                        m_led = 16'h1; m_left = 1'b1;
                    end else begin
                        p = $clog2(m_led);
                        if (m_left) begin
                            if (p == 15) begin p = 14; m_left = 1'b0; end
                            else p = p + 1;
                        end else begin
                            if (p == 0) begin p = 1; m_left = 1'b1; end
                            else begin p = p - 1; if (p == 0) m_wrap = 1; end
                        end
                        m_led = 16'(1 << p);
                    end
                end
                3: begin
                    v = (int'(m_led) + 1) % 65536;
                    if (v == 0) m_wrap = 1;
                    m_led = 16'(v);
                end
                default: ;
            endcase
        end
    endtask

    int last_w;
    int last_w4;

    // op 0: tick pulse (10 high, 10 low); op 1: set mode; op 2: set pause.
    task automatic apply(input int op, input int arg);
        int w0;
        int w40;
        w0  = wrap_cnt;
        w40 = wrap4_cnt;
        @(negedge clk);
        case (op)
            0: tick_in = 1'b1;
            1: mode = arg[1:0];
            default: pause = arg[0];
        endcase
        repeat (10) @(negedge clk);
        tick_in = 1'b0;
        repeat (10) @(negedge clk);
        last_w  = wrap_cnt - w0;
        last_w4 = wrap4_cnt - w40;
    endtask

    typedef struct {
        int          op;
        int          arg;
        logic [15:0] led;
        int          wrap;
    } vec_t;

    function automatic vec_t mk(input int op, input int arg, input logic [15:0] l, input int w);
        vec_t r;
        r.op = op; r.arg = arg; r.led = l; r.wrap = w;
        return r;
    endfunction

    initial begin
        vec_t vt[$];
        logic [15:0] prev;
        logic [3:0]  prev4;
        int lat;
        int lat4;
        int w0;

        // ROTATE remainder (first step comes from the latency test).
        for (int i = 2; i <= 15; i++) vt.push_back(mk(0, 0, 16'(1 << i), 0));
        vt.push_back(mk(0, 0, 16'h0001, 1));
        // BOUNCE: 15 up, 15 down, wrap on the last.
        vt.push_back(mk(1, 2, 16'h0001, 0));
        for (int i = 1; i <= 15; i++) vt.push_back(mk(0, 0, 16'(1 << i), 0));
        for (int i = 14; i >= 1; i--) vt.push_back(mk(0, 0, 16'(1 << i), 0));
        vt.push_back(mk(0, 0, 16'h0001, 1));
        // Pause suppresses steps without queuing them.
        vt.push_back(mk(2, 1, 16'h0001, 0));
        for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 16'h0001, 0));
        vt.push_back(mk(2, 0, 16'h0001, 0));
        vt.push_back(mk(0, 0, 16'h0002, 0));
        vt.push_back(mk(1, 1, 16'h0001, 0));

        // Reset with ROTATE selected.
        w0 = wrap_cnt;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_led4", 32'(led4), 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) check("seed_not_early", 32'(led), 32'h0);
            if (e == 3) check("seed_edge3", 32'(led), 32'h1);
        end
        repeat (6) @(negedge clk);
        check("seed_wrap", 32'(wrap_cnt - w0), 32'h0);
        check("seed_led4", 32'(led4), 32'h1);
        m_mode = 1; m_led = 16'h1; m_left = 1'b1;

        // Latency: tick rise to LED change, both synchronizer depths.
        prev = led; prev4 = led4; lat = 0; lat4 = 0;
        tick_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && led != prev) lat = k;
            if (lat4 == 0 && led4 != prev4) lat4 = k;
        end
        check("latency_sync2", 32'(lat), 32'd4);
        check("latency_sync4", 32'(lat4), 32'd6);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (10) @(negedge clk);
        model_op(0, 0);
        check("latency_led", 32'(led), 32'(m_led));
        check("latency_table_led", 32'(led), 32'h2);

        foreach (vt[i]) begin
            apply(vt[i].op, vt[i].arg);
            model_op(vt[i].op, vt[i].arg);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].led));
            check($sformatf("vec%0d_wrap", i), 32'(last_w), 32'(vt[i].wrap));
        end

        // Step and mode change (01->11) land in the same cycle.
        w0 = wrap_cnt;
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        mode = 2'b11;
        repeat (9) @(negedge clk);
        tick_in = 1'b0;
        repeat (10) @(negedge clk);
        model_op(1, 3);
        check("prio_led", 32'(led), 32'h0);
        check("prio_wrap", 32'(wrap_cnt - w0), 32'h0);

        // COUNT wrap on the 4-bit instance.
        apply(1, 0); model_op(1, 0);
        apply(1, 3); model_op(1, 3);
        check("count_seed4", 32'(led4), 32'h0);
        for (int i = 0; i < 14; i++) begin apply(0, 0); model_op(0, 0); end
        check("count14_led4", 32'(led4), 32'hE);
        check("count14_led", 32'(led), 32'(m_led));
        apply(0, 0); model_op(0, 0);
        check("count15_led4", 32'(led4), 32'hF);
        check("count15_wrap4", 32'(last_w4), 32'h0);
        apply(0, 0); model_op(0, 0);
        check("count16_led4", 32'(led4), 32'h0);
        check("count16_wrap4", 32'(last_w4), 32'h1);
        check("count16_led", 32'(led), 32'(m_led));

        // Randomized operations.
        for (int i = 0; i < 120; i++) begin
            int r;
            int op;
            int arg;
            r = int'($urandom_range(0, 9));
            op = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            arg = (op == 1) ? int'($urandom_range(0, 3)) : (op == 2) ? int'($urandom_range(0, 1)) : 0;
            apply(op, arg);
            model_op(op, arg);
            check($sformatf("rnd%0d_led", i), 32'(led), 32'(m_led));
            check($sformatf("rnd%0d_wrap", i), 32'(last_w), 32'(m_wrap));
        end

        // Mid-pattern reset, released with BOUNCE selected and tick already high.
        apply(2, 0); model_op(2, 0);
        apply(1, 1); model_op(1, 1);
        apply(0, 0); model_op(0, 0);
        check("pre_reset_led", 32'(led), 32'h2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        mode = 2'b10;
        tick_in = 1'b1;
        #1;
        check("async_reset_led", 32'(led), 32'h0);
        check("async_reset_wrap", 32'(wrap), 32'h0);
        repeat (3) @(negedge clk);
        w0 = wrap_cnt;
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) check("rel_seed", 32'(led), 32'h1);
            if (e == 4) check("rel_step", 32'(led), 32'h2);
        end
        repeat (8) @(negedge clk);
        tick_in = 1'b0;
        repeat (12) @(negedge clk);
        m_mode = 2; m_led = 16'h1; m_left = 1'b1; m_pause = 1'b0;
        model_op(0, 0);
        check("rel_one_step", 32'(led), 32'(m_led));
        check("rel_wrap", 32'(wrap_cnt - w0), 32'h0);
        apply(0, 0); model_op(0, 0);
        check("rel_next", 32'(led), 32'(m_led));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
